program_loader: RTL and testbench
=================================

# program_loader

Boot-time instruction loader sitting directly upstream of the `RISC_V` top level. It accepts a byte stream over a valid/ready handshake, frames it as a 16-bit instruction count followed by little-endian 32-bit instructions, and writes each word into the IF-stage instruction memory through the core's `rw` / `PC_write` / `instruction_in` / `reset_IF_memory` inputs. While a load is in progress it holds the pipeline in reset, and releases the pipeline once the last instruction is written.

## Interface
- `PC_SIZE`, 10: width of `PC_write`; must match the core.
- `PC_STEP`, 4: address increment per instruction (byte-addressed PC).
- `MAX_WORDS`, 2**PC_SIZE/PC_STEP (256): largest legal instruction count.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  rising-edge clock shared with the core.
- `reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- `start`  in  1  single-cycle request to begin a load.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `rw`  out  1  1 = write `instruction_in` to IF memory at `PC_write`.
- `reset_IF_memory`  out  1  single-cycle clear of IF memory.
- `PC_write`  out  PC_SIZE  write address.
- `instruction_in`  out  32  assembled instruction.
- `core_hold`  out  1  1 = pipeline must be held in reset (top-level glue maps this to the core reset).
- `busy`  out  1  load in progress.
- `done`  out  1  last load completed successfully (level).
- `error`  out  1  last load rejected (level).
- `loaded_count`  out  PC_SIZE+1  instructions written in the current or last load.

## Operation
- States: IDLE, CLEAR, LEN_LO, LEN_HI, BYTE, WRITE, DONE, ERROR.
- Byte transfer: a byte is consumed on the rising edge where `rx_valid && rx_ready`. `rx_ready` is combinational from state: it is 1 only in LEN_LO, LEN_HI and BYTE. `rx_data` is ignored otherwise.
- IDLE: `core_hold`=1. `start` moves to CLEAR.
- CLEAR (1 cycle): `reset_IF_memory`=1. Address, count and byte index are zeroed. Next state is LEN_LO.
- LEN_LO / LEN_HI: capture N[7:0], then N[15:8].
  - On LEN_HI acceptance: N==0 or N>MAX_WORDS goes to ERROR; otherwise goes to BYTE.
- BYTE: accepted byte k (k=0..3) lands in `instruction_in[8k+7:8k]`. Acceptance of k=3 goes to WRITE.
- WRITE (exactly 1 cycle): `rw`=1, with `PC_write` and `instruction_in` stable. On exit:
  - address += PC_STEP (mod 2**PC_SIZE);
  - `loaded_count` += 1;
  - byte index is cleared;
  - next state is DONE if `loaded_count`+1==N, else BYTE.
- DONE: `core_hold`=0, `done`=1. `start` goes to CLEAR and clears `done`.
- ERROR: `core_hold`=1, `error`=1. `start` goes to CLEAR and clears `error`. No bytes are consumed.
- `start` is ignored in CLEAR, LEN_LO, LEN_HI, BYTE and WRITE.
- `busy`=1 in CLEAR through WRITE.
- `core_hold`=1 in every state except DONE.
- `rw` and `reset_IF_memory` are never asserted in the same cycle.
- `instruction_in` and `PC_write` hold their last values outside WRITE.

## Timing
- Reset values: state IDLE, `core_hold`=1, all other outputs 0, `PC_write`=0, `instruction_in`=0, `loaded_count`=0.
- `start` to `reset_IF_memory` pulse: 1 cycle (registered state). The first byte can be accepted in the cycle after CLEAR.
- Minimum per instruction: 4 accepted-byte cycles + 1 WRITE cycle = 5 cycles. Gaps in `rx_valid` stretch BYTE without limit.
- `core_hold` falls in the cycle after the final WRITE, i.e. the first cycle in DONE.
- Reset asserted mid-load returns to IDLE immediately.
  - Partially written IF memory is left as is; `core_hold` stays 1.
  - Any byte on that edge is not consumed.
- Address wrap is unreachable for legal N; N==MAX_WORDS ends with the final write at address (MAX_WORDS-1)*PC_STEP.

## Test plan
- Load N=2, bytes 02 00 13 05 10 00 93 05 20 00:
  - `reset_IF_memory` pulse, then `rw` pulses with (PC_write=0, 0x00100513) and (4, 0x00200593);
  - `done`=1, `core_hold`=0, `loaded_count`=2.
- Same stream with `rx_valid` low for 3 cycles between every byte: identical writes. `rw` is never high while `rx_ready` is high.
- N=0 (bytes 00 00) and N=257 (01 01): `error`=1, `core_hold`=1, no `rw` pulse, `rx_ready` stays 0 afterwards.
- N=256 full load: 256 writes, last at PC_write=0x3FC, `loaded_count`=256, `done`=1.
- Reset low mid-word during the 2nd instruction: outputs return to reset values asynchronously. A subsequent `start` with N=1 loads at address 0.
- From DONE, pulse `start` and load N=1: `done` drops, `core_hold`=1 through the load, then `done`=1 again with `loaded_count`=1. A `start` pulse mid-load has no effect.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time loader: frames a byte stream (16-bit count + LE 32-bit words) into
// IF-memory writes, holding the core in reset until the last word lands.
module program_loader #(
   parameter int unsigned PC_SIZE = 10,
   parameter int unsigned PC_STEP = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output logic               rw,
   output logic               reset_IF_memory,
   output logic [PC_SIZE-1:0] PC_write,
   output logic [31:0]        instruction_in,
   output logic               core_hold,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [PC_SIZE:0]   loaded_count
);

   localparam int unsigned MAX_WORDS = (2 ** PC_SIZE) / PC_STEP;

   typedef enum logic [2:0] {
      IDLE, CLEAR, LEN_LO, LEN_HI, BYTE, WRITE, DONE, ERROR
   } state_t;

   state_t               state, state_d;
   logic [15:0]          len_q;
   logic [PC_SIZE-1:0]   addr_q;
   logic [1:0]           byte_idx_q;
   logic [23:0]          word_q;
   logic                 accept;
   logic [15:0]          len_full;
   logic                 last_word;

   // Next-state decode; byte acceptance follows the registered rx_ready
   always_comb begin
      state_d   = state;
      accept    = rx_valid && rx_ready;
      len_full  = {rx_data, len_q[7:0]};
      last_word = ((16'(loaded_count) + 16'd1) == len_q);
      case (state)
         IDLE:   if (start) state_d = CLEAR;
         CLEAR:  state_d = LEN_LO;
         LEN_LO: if (accept) state_d = LEN_HI;
         LEN_HI: if (accept) begin
            if ((len_full == 16'd0) || (len_full > 16'(MAX_WORDS))) state_d = ERROR;
            else                                                     state_d = BYTE;
         end
         BYTE:   if (accept && (byte_idx_q == 2'd3)) state_d = WRITE;
         WRITE:  state_d = last_word ? DONE : BYTE;
         DONE:   if (start) state_d = CLEAR;
         ERROR:  if (start) state_d = CLEAR;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_d;
   end

   // Framing datapath: length capture, byte assembly, address/count stepping
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         len_q        <= 16'd0;
         addr_q       <= '0;
         byte_idx_q   <= 2'd0;
         word_q       <= 24'd0;
         loaded_count <= '0;
      end else begin
         case (state)
            CLEAR: begin
               addr_q       <= '0;
               byte_idx_q   <= 2'd0;
               loaded_count <= '0;
            end
            LEN_LO: if (accept) len_q[7:0]  <= rx_data;
            LEN_HI: if (accept) len_q[15:8] <= rx_data;
            BYTE: if (accept) begin
               case (byte_idx_q)
                  2'd0:    word_q[7:0]   <= rx_data;
                  2'd1:    word_q[15:8]  <= rx_data;
                  2'd2:    word_q[23:16] <= rx_data;
                  default: ;
               endcase
               byte_idx_q <= byte_idx_q + 2'd1;
            end
            WRITE: begin
               addr_q       <= addr_q + PC_SIZE'(PC_STEP);
               loaded_count <= loaded_count + (PC_SIZE + 1)'(1);
               byte_idx_q   <= 2'd0;
            end
            default: ;
         endcase
      end
   end

   // Outputs registered from the next state so they line up with the state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_ready        <= 1'b0;
         rw              <= 1'b0;
         reset_IF_memory <= 1'b0;
         PC_write        <= '0;
         instruction_in  <= 32'd0;
         core_hold       <= 1'b1;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
      end else begin
         rx_ready        <= (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == BYTE);
         rw              <= (state_d == WRITE);
         reset_IF_memory <= (state_d == CLEAR);
         core_hold       <= (state_d != DONE);
         busy            <= (state_d == CLEAR) || (state_d == LEN_LO) || (state_d == LEN_HI) ||
                            (state_d == BYTE)  || (state_d == WRITE);
         done            <= (state_d == DONE);
         error           <= (state_d == ERROR);
         if (state_d == WRITE) begin
            PC_write       <= addr_q;
            instruction_in <= {rx_data, word_q};
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random loads compared
// against a stream-level model of the expected IF-memory writes.
module tb_program_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready, rw, reset_IF_memory, core_hold, busy, done, error;
   logic [9:0]  PC_write;
   logic [31:0] instruction_in;
   logic [10:0] loaded_count;

   int errors = 0;
   int checks = 0;

   logic [41:0] wq[$];
   int clr_cnt  = 0;
   int overlap  = 0;
   int hold_bad = 0;

   program_loader dut (
      .clock(clock), .reset(reset), .start(start), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rw(rw),
      .reset_IF_memory(reset_IF_memory), .PC_write(PC_write),
      .instruction_in(instruction_in), .core_hold(core_hold), .busy(busy),
      .done(done), .error(error), .loaded_count(loaded_count)
   );

   always #5 clock = ~clock;

   // Passive observer of the IF-memory write port
   always @(negedge clock) begin
      if (rw) wq.push_back({PC_write, instruction_in});
      if (reset_IF_memory) clr_cnt++;
      if (rw && (rx_ready || reset_IF_memory)) overlap++;
      if (busy && !core_hold) hold_bad++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start();
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
   endtask

   task automatic send_byte(input byte unsigned b, input int gmin, input int gmax);
      int budget;
      int g;
      g = (gmax > gmin) ? int'($urandom_range(gmax, gmin)) : gmin;
      @(negedge clock);
      repeat (g) @(negedge clock);
      rx_valid = 1'b1;
      rx_data  = b;
      budget   = 0;
      while (!rx_ready && budget < 200) begin
         @(negedge clock);
         budget++;
      end
      if (!rx_ready) begin
         checks++;
         errors++;
         $error("FAIL rx_accept observed=timeout expected=rx_ready");
      end
      @(posedge clock);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_range(input byte unsigned s[$], input int from, input int to,
                             input int gmin, input int gmax);
      for (int i = from; i < to; i++) send_byte(s[i], gmin, gmax);
   endtask

   task automatic wait_end(input string tag);
      int b;
      b = 0;
      while (!(done || error) && b < 3000) begin
         @(negedge clock);
         b++;
      end
      if (!(done || error)) begin
         checks++;
         errors++;
         $error("FAIL %s_end observed=timeout expected=done_or_error", tag);
      end
   endtask

   // Model: decode the stream into the write list and completion status
   task automatic check_load(input string tag, input byte unsigned s[$]);
      int n;
      bit bad;
      logic [31:0] w;
      n   = int'(s[0]) | (int'(s[1]) << 8);
      bad = (n == 0) || (n > 256);
      chk({tag, "_clr"}, 64'(clr_cnt), 64'd1);
      chk({tag, "_error"}, 64'(error), 64'(bad));
      chk({tag, "_done"}, 64'(done), 64'(!bad));
      chk({tag, "_hold"}, 64'(core_hold), 64'(bad));
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_count"}, 64'(loaded_count), bad ? 64'd0 : 64'(n));
      chk({tag, "_nwrites"}, 64'(wq.size()), bad ? 64'd0 : 64'(n));
      if (!bad && wq.size() == n) begin
         for (int i = 0; i < n; i++) begin
            w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
            chk({tag, "_write"}, 64'(wq[i]), 64'({10'((i * 4) % 1024), w}));
         end
      end
   endtask

   task automatic run_load(input string tag, input byte unsigned s[$], input int gmin, input int gmax);
      wq.delete();
      clr_cnt = 0;
      do_start();
      send_range(s, 0, s.size(), gmin, gmax);
      wait_end(tag);
      check_load(tag, s);
   endtask

   function automatic void make_stream(output byte unsigned s[$], input int n);
      logic [31:0] w;
      s.delete();
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         for (int k = 0; k < 4; k++) s.push_back(w[8*k +: 8]);
      end
   endfunction

   initial begin
      byte unsigned s[$];
      byte unsigned base[$];

      // Reset state
      #12;
      chk("rst_hold", 64'(core_hold), 64'd1);
      chk("rst_outs", 64'({rx_ready, rw, reset_IF_memory, busy, done, error}), 64'd0);
      chk("rst_pc", 64'(PC_write), 64'd0);
      chk("rst_instr", 64'(instruction_in), 64'd0);
      chk("rst_count", 64'(loaded_count), 64'd0);
      @(negedge clock) reset = 1'b1;

      // Directed N=2 load, back-to-back then with 3-cycle gaps
      base = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      run_load("n2", base, 0, 0);
      chk("n2_w0", 64'(wq[0]), 64'({10'h000, 32'h00100513}));
      run_load("n2gap", base, 3, 3);
      chk("n2gap_w1", 64'(wq[1]), 64'({10'h004, 32'h00200593}));

      // Illegal counts
      s = '{8'h00, 8'h00};
      run_load("n0", s, 0, 0);
      rx_valid = 1'b1;
      repeat (5) @(negedge clock);
      chk("n0_noready", 64'(rx_ready), 64'd0);
      chk("n0_still_err", 64'(error), 64'd1);
      rx_valid = 1'b0;
      s = '{8'h01, 8'h01};
      run_load("n257", s, 0, 0);

      // Full-size load
      make_stream(s, 256);
      run_load("n256", s, 0, 0);
      if (wq.size() > 0) chk("n256_last_pc", 64'(wq[wq.size()-1][41:32]), 64'h3FC);

      // Reset during the second instruction
      make_stream(s, 3);
      wq.delete();
      do_start();
      send_range(s, 0, 8, 0, 1);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("arst_hold", 64'(core_hold), 64'd1);
      chk("arst_outs", 64'({rx_ready, rw, reset_IF_memory, busy, done, error}), 64'd0);
      chk("arst_pc_instr", 64'({PC_write, instruction_in}), 64'd0);
      chk("arst_count", 64'(loaded_count), 64'd0);
      chk("arst_partial", 64'(wq.size()), 64'd1);
      @(negedge clock) reset = 1'b1;
      make_stream(s, 1);
      run_load("after_rst", s, 0, 0);

      // Reload from DONE with a stray start mid-load
      make_stream(s, 1);
      wq.delete();
      clr_cnt = 0;
      do_start();
      chk("reload_done_low", 64'(done), 64'd0);
      chk("reload_hold", 64'(core_hold), 64'd1);
      send_range(s, 0, 4, 0, 0);
      do_start();
      send_range(s, 4, 6, 0, 0);
      wait_end("reload");
      check_load("reload", s);

      // Random loads with random gaps
      for (int r = 0; r < 4; r++) begin
         make_stream(s, int'($urandom_range(7, 1)));
         run_load("rand", s, 0, 3);
      end

      chk("no_rw_overlap", 64'(overlap), 64'd0);
      chk("hold_while_busy", 64'(hold_bad), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
